regex_stream_ctx: RTL and testbench
===================================

# regex_stream_ctx

Parametrised per-stream context manager for a single DPI regex engine. It saves and restores the engine's DFA state across packets of up to NUM_STREAMS interleaved streams, and tracks a per-packet match flag. It also keeps a saturating global match count and per-stream match counts. It sits between the packet-inspection front end (stream lookup, character feed) and one regex engine instance, and is engine-agnostic: it drives the engine's state-load port and observes its state/accept outputs.

## Interface
Parameters:
- STATE_W, 11, engine DFA state width
- NUM_STREAMS, 64, number of stream contexts (power of 2)
- SID_W, 6, stream id width, log2(NUM_STREAMS)
- COUNT_W, 16, width of global and per-stream counters

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- load_state  in  1  start-of-packet pulse; samples stream_id / new_stream_id
- new_stream_id  in  1  stream unknown to front end; force initial state 0
- stream_id  in  SID_W  stream of current packet; valid with load_state and eop
- enable  in  1  regex enabled for this stream; sampled with eop
- eop  in  1  end-of-packet pulse; commits packet
- clr_counts  in  1  synchronous clear of all counters
- eng_state_out  in  STATE_W  engine current state
- eng_accept  in  1  engine accept pulse
- eng_state_in  out  STATE_W  state to load into engine
- eng_state_in_vld  out  1  load strobe to engine, one cycle
- fired  out  1  current/last packet matched
- total_count  out  COUNT_W  packets matched, all enabled streams, saturating
- rd_sid  in  SID_W  per-stream count read address
- rd_count  out  COUNT_W  match count of rd_sid, registered
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Context store: NUM_STREAMS x STATE_W state array plus NUM_STREAMS valid bits. Only the valid bits are reset (to 0); array contents are don't-care until written.
- FSM: IDLE, ACTIVE.
  - IDLE --load_state--> ACTIVE.
  - ACTIVE --eop--> IDLE.
  - ACTIVE with eop and load_state in the same cycle: commit the old packet, start the new one, stay ACTIVE.
- Load (load_state=1):
  - Next cycle, eng_state_in_vld=1.
  - eng_state_in = 0 if new_stream_id=1 or valid[stream_id]=0; otherwise the stored state.
  - Bypass: if a commit to the same stream_id happens in the same cycle, eng_state_in = eng_state_out of that cycle, not the stale array value.
  - fired cleared.
- Match: eng_accept=1 while ACTIVE sets fired. Accept is ignored in IDLE.
- Commit (eop=1 while ACTIVE), keyed by stream_id:
  - enable=1:
    - state_mem[sid] <= eng_state_out; valid[sid] <= 1.
    - If fired or eng_accept this cycle: total_count and cnt[sid] each +1, saturating at 2^COUNT_W-1.
    - fired keeps its value (OR eng_accept).
  - enable=0: no state write, counters unchanged, fired cleared.
- clr_counts: total_count and all cnt[] set to 0; it overrides a same-cycle increment. State and valid bits are untouched.
- Protocol errors set proto_err, which stays set until reset:
  - eop in IDLE: ignored, no commit.
  - load_state in ACTIVE without eop: the new load takes effect, and the old packet is dropped with no commit.

## Timing
- Reset values: eng_state_in=0, eng_state_in_vld=0, fired=0, total_count=0, rd_count=0, proto_err=0, FSM=IDLE, valid[]=0.
- load_state at cycle T → eng_state_in_vld high in T+1 only. The front end may present the first char_in_vld to the engine no earlier than T+2.
- eng_accept at T → fired high from T+1.
- eop at T → total_count / cnt updated, visible at T+1.
- rd_count: 1-cycle latency from rd_sid, reflecting counters as of the previous edge.
- Increments saturate; there is no wrap-around.
- Reset mid-packet returns to IDLE, and all contexts become invalid.

## Test plan
- Stream 5, new_stream_id=1; engine accepts once; eop with enable=1 → fired=1, total_count=1, cnt[5]=1; next load of sid 5 (new_stream_id=0) gives eng_state_in = saved eng_state_out.
- Interleave sids 3 and 9 with distinct engine states 0x12 and 0x7F → each reload returns its own state; a never-committed sid 20 with new_stream_id=0 loads 0.
- eop and load of the same sid 7 in one cycle, eng_state_out=0x2A → eng_state_in=0x2A next cycle, and cnt[7] increments if fired.
- eop with enable=0 after an accept → fired=0, counters unchanged, state_mem not written; reload gives the prior state.
- Preload total_count to 0xFFFE with two matching packets → reaches 0xFFFF and holds; clr_counts coincident with an eop match → 0.
- eop while IDLE, then load, load without eop → proto_err=1 and sticky; the first packet is not committed.

Source files
------------

// File: rtl/regex_stream_ctx.sv
// regex_stream_ctx: per-stream DFA state save/restore, match flag and match counters for one regex engine
module regex_stream_ctx #(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_state,
    input  logic               new_stream_id,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               enable,
    input  logic               eop,
    input  logic               clr_counts,
    input  logic [STATE_W-1:0] eng_state_out,
    input  logic               eng_accept,
    output logic [STATE_W-1:0] eng_state_in,
    output logic               eng_state_in_vld,
    output logic               fired,
    output logic [COUNT_W-1:0] total_count,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [COUNT_W-1:0] rd_count,
    output logic               proto_err
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    state_t st, st_nx;
    logic [STATE_W-1:0] state_mem [NUM_STREAMS];
    logic [COUNT_W-1:0] cnt [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid;
    logic commit, wr, inc, err, fired_nx;
    always_comb begin
        commit   = eop && st == ACTIVE;
        wr       = commit && enable;
        inc      = wr && (fired || eng_accept);
        err      = (eop && st == IDLE) || (load_state && st == ACTIVE && !eop);
        st_nx    = load_state ? ACTIVE : commit ? IDLE : st;
        fired_nx = load_state ? 1'b0 : st == IDLE ? fired : (eop && !enable) ? 1'b0 : fired | eng_accept;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st               <= IDLE;
            eng_state_in     <= '0;
            eng_state_in_vld <= 1'b0;
            fired            <= 1'b0;
            total_count      <= '0;
            rd_count         <= '0;
            proto_err        <= 1'b0;
            valid            <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
        end else begin
            st               <= st_nx;
            fired            <= fired_nx;
            eng_state_in_vld <= load_state;
            proto_err        <= proto_err | err;
            rd_count         <= cnt[rd_sid];
            // a same-cycle commit is the freshest context, so it bypasses the array
            if (load_state)
                eng_state_in <= new_stream_id ? '0 : wr ? eng_state_out :
                                valid[stream_id] ? state_mem[stream_id] : '0;
            if (wr) valid[stream_id] <= 1'b1;
            if (clr_counts) begin
                total_count <= '0;
                for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
            end else if (inc) begin
                if (total_count != CNT_MAX) total_count <= total_count + 1'b1;
                if (cnt[stream_id] != CNT_MAX) cnt[stream_id] <= cnt[stream_id] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr) state_mem[stream_id] <= eng_state_out;
    end
endmodule

// File: tb/tb_regex_stream_ctx.sv
// tb_regex_stream_ctx: directed and random checks of regex_stream_ctx against a packet-level model
module tb_regex_stream_ctx;
    localparam int CMAX = 15;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_state = 1'b0, new_stream_id = 1'b0, enable = 1'b0, eop = 1'b0;
    logic        clr_counts = 1'b0, eng_accept = 1'b0;
    logic [5:0]  stream_id = '0, rd_sid = '0;
    logic [10:0] eng_state_out = '0;
    logic [10:0] eng_state_in;
    logic        eng_state_in_vld, fired, proto_err;
    logic [3:0]  total_count, rd_count;
    int total = 0, bad = 0;

    logic [10:0] mstate [64];
    bit          mvalid [64];
    int          mcnt [64];
    int          mtot, erd;
    bit          mf, mact, merr, evld;
    logic [10:0] ein;

    regex_stream_ctx #(.STATE_W(11), .NUM_STREAMS(64), .SID_W(6), .COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_state(load_state), .new_stream_id(new_stream_id),
        .stream_id(stream_id), .enable(enable), .eop(eop), .clr_counts(clr_counts),
        .eng_state_out(eng_state_out), .eng_accept(eng_accept), .eng_state_in(eng_state_in),
        .eng_state_in_vld(eng_state_in_vld), .fired(fired), .total_count(total_count),
        .rd_sid(rd_sid), .rd_count(rd_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".vld"}, 32'(eng_state_in_vld), 32'(evld));
        check({tag, ".in"}, 32'(eng_state_in), 32'(ein));
        check({tag, ".fired"}, 32'(fired), 32'(mf));
        check({tag, ".total"}, 32'(total_count), 32'(mtot));
        check({tag, ".rd"}, 32'(rd_count), 32'(erd));
        check({tag, ".err"}, 32'(proto_err), 32'(merr));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load_state = 0; eop = 0; clr_counts = 0; eng_accept = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (mvalid[i]) begin mvalid[i] = 0; mcnt[i] = 0; end
        mtot = 0; mf = 0; mact = 0; merr = 0; evld = 0; ein = '0; erd = 0;
        check_all("reset");
    endtask

    // one clock: drive inputs, advance the packet-level model, check outputs after the edge
    task automatic step(input string tag, input bit ld, input bit nw, input int sid, input bit en,
                        input bit ep, input bit cl, input logic [10:0] so, input bit acc, input int rs);
        bit commit, wr, inc;
        load_state = ld; new_stream_id = nw; stream_id = 6'(sid); enable = en; eop = ep;
        clr_counts = cl; eng_state_out = so; eng_accept = acc; rd_sid = 6'(rs);
        commit = ep && mact;
        wr = commit && en;
        inc = wr && (mf || acc);
        evld = ld;
        if (ld) ein = nw ? 11'h0 : (wr ? so : (mvalid[sid] ? mstate[sid] : 11'h0));
        erd = mcnt[rs];
        if (cl) begin
            mtot = 0;
            foreach (mcnt[i]) mcnt[i] = 0;
        end else if (inc) begin
            if (mtot < CMAX) mtot++;
            if (mcnt[sid] < CMAX) mcnt[sid]++;
        end
        if (ld) mf = 0;
        else if (mact) mf = (ep && !en) ? 1'b0 : (mf | acc);
        if ((ep && !mact) || (ld && mact && !ep)) merr = 1;
        if (wr) begin mstate[sid] = so; mvalid[sid] = 1; end
        mact = ld ? 1'b1 : (ep ? 1'b0 : mact);
        @(posedge clk); #1;
        load_state = 0; eop = 0; clr_counts = 0; eng_accept = 0; new_stream_id = 0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int rs);
        step(tag, 0, 0, 0, 0, 0, 0, 11'h0, 0, rs);
    endtask

    initial begin
        do_reset();
        // new stream 5, one accept, committed
        step("t1_load", 1, 1, 5, 0, 0, 0, 11'h000, 0, 0);
        check("t1_in0", 32'(eng_state_in), 32'h0);
        step("t1_acc", 0, 0, 5, 0, 0, 0, 11'h0AB, 1, 0);
        check("t1_fired", 32'(fired), 32'h1);
        step("t1_eop", 0, 0, 5, 1, 1, 0, 11'h0AB, 0, 5);
        check("t1_total", 32'(total_count), 32'h1);
        idle("t1_rd", 5);
        check("t1_cnt5", 32'(rd_count), 32'h1);
        step("t1_reload", 1, 0, 5, 0, 0, 0, 11'h000, 0, 0);
        check("t1_restore", 32'(eng_state_in), 32'h0AB);
        step("t1_close", 0, 0, 5, 0, 1, 0, 11'h0AB, 0, 0);
        // interleaved sids 3 and 9, never-committed sid 20
        step("t2_l3", 1, 1, 3, 0, 0, 0, 11'h000, 0, 0);
        step("t2_e3", 0, 0, 3, 1, 1, 0, 11'h012, 0, 0);
        step("t2_l9", 1, 1, 9, 0, 0, 0, 11'h000, 0, 0);
        step("t2_e9", 0, 0, 9, 1, 1, 0, 11'h07F, 0, 0);
        step("t2_r3", 1, 0, 3, 0, 0, 0, 11'h000, 0, 0);
        check("t2_st3", 32'(eng_state_in), 32'h012);
        step("t2_e3b", 0, 0, 3, 1, 1, 0, 11'h012, 0, 0);
        step("t2_r9", 1, 0, 9, 0, 0, 0, 11'h000, 0, 0);
        check("t2_st9", 32'(eng_state_in), 32'h07F);
        step("t2_e9b", 0, 0, 9, 1, 1, 0, 11'h07F, 0, 0);
        step("t2_r20", 1, 0, 20, 0, 0, 0, 11'h000, 0, 0);
        check("t2_st20", 32'(eng_state_in), 32'h0);
        step("t2_e20", 0, 0, 20, 0, 1, 0, 11'h055, 0, 0);
        // same-cycle eop+load of sid 7 bypasses the array
        step("t3_l7", 1, 1, 7, 0, 0, 0, 11'h000, 0, 0);
        step("t3_acc", 0, 0, 7, 0, 0, 0, 11'h010, 1, 0);
        step("t3_both", 1, 0, 7, 1, 1, 0, 11'h02A, 0, 7);
        check("t3_bypass", 32'(eng_state_in), 32'h02A);
        idle("t3_rd", 7);
        check("t3_cnt7", 32'(rd_count), 32'h1);
        // disabled commit after accept: no write, no count
        step("t4_acc", 0, 0, 7, 0, 0, 0, 11'h033, 1, 0);
        step("t4_eop", 0, 0, 7, 0, 1, 0, 11'h033, 0, 0);
        check("t4_fired", 32'(fired), 32'h0);
        step("t4_rl", 1, 0, 7, 0, 0, 0, 11'h000, 0, 0);
        check("t4_prior", 32'(eng_state_in), 32'h02A);
        step("t4_e", 0, 0, 7, 0, 1, 0, 11'h000, 0, 0);
        // saturation, then clear coincident with a matching eop
        for (int i = 0; i < 16; i++) begin
            step("t5_l", 1, 0, 11, 0, 0, 0, 11'h000, 0, 0);
            step("t5_e", 0, 0, 11, 1, 1, 0, 11'h001, 1, 11);
        end
        check("t5_sat", 32'(total_count), 32'hF);
        idle("t5_rd", 11);
        check("t5_cnt_sat", 32'(rd_count), 32'hF);
        step("t5_l2", 1, 0, 11, 0, 0, 0, 11'h000, 0, 0);
        step("t5_clr", 0, 0, 11, 1, 1, 1, 11'h001, 1, 0);
        check("t5_clr0", 32'(total_count), 32'h0);
        check("t5_err0", 32'(proto_err), 32'h0);
        // protocol errors
        step("t6_eop_idle", 0, 0, 4, 1, 1, 0, 11'h044, 1, 0);
        check("t6_err", 32'(proto_err), 32'h1);
        step("t6_l", 1, 0, 3, 0, 0, 0, 11'h000, 0, 0);
        step("t6_acc", 0, 0, 3, 0, 0, 0, 11'h066, 1, 0);
        step("t6_reld", 1, 0, 3, 0, 0, 0, 11'h066, 0, 3);
        check("t6_nocommit", 32'(eng_state_in), 32'h012);
        step("t6_e", 0, 0, 3, 1, 1, 0, 11'h012, 0, 0);
        check("t6_sticky", 32'(proto_err), 32'h1);
        // reset mid-packet invalidates contexts
        step("t7_l", 1, 0, 9, 0, 0, 0, 11'h000, 0, 0);
        do_reset();
        step("t7_r9", 1, 0, 9, 0, 0, 0, 11'h000, 0, 0);
        check("t7_inval", 32'(eng_state_in), 32'h0);
        step("t7_e", 0, 0, 9, 1, 1, 0, 11'h0AA, 0, 0);
        for (int i = 0; i < 500; i++)
            step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                 11'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
